// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg : RV32I constants and types shared by fetch, decode, immgen   |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
package rv32_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : imem request/response, redirect and decode handshake   |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_unit_if;

  logic                       imem_req;
  logic [rv32_pkg::XLEN-1:0]  imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [rv32_pkg::XLEN-1:0]  imem_rdata;
  logic                       redirect;
  logic [rv32_pkg::XLEN-1:0]  redirect_pc;
  logic                       inst_valid;
  logic                       inst_ready;
  logic [rv32_pkg::XLEN-1:0]  inst;
  logic [rv32_pkg::XLEN-1:0]  inst_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry prefetch FIFO of {pc, inst}, head readable    |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  fetch_entry_t          push_data,
  input  logic                  pop,
  input  logic                  flush,
  output fetch_entry_t          head,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_pop;

  assign w_pop = pop & (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !flush && full && !w_pop));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : RV32I fetch stage, PC/issue, in-order response tracking   |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occupancy;
  logic [CW-1:0]   w_outstanding_next;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  assign w_occupancy = {1'b0, w_count} + {1'b0, r_outstanding};

  // Never issue during reset or a redirect: the address would be stale.
  assign bus.imem_req  = reset && !bus.redirect && (w_occupancy < (CW+1)'(DEPTH));
  assign bus.imem_addr = r_pc;

  assign w_grant            = bus.imem_req & bus.imem_gnt;
  assign w_outstanding_next = r_outstanding + CW'(w_grant) - CW'(bus.imem_rvalid);

  assign w_push      = bus.imem_rvalid && !bus.redirect && (r_discard == '0);
  assign w_push_data = '{pc: r_resp_pc, inst: bus.imem_rdata};
  assign w_pop       = bus.inst_valid & bus.inst_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (bus.redirect) begin
        r_pc      <= word_align(bus.redirect_pc);
        r_resp_pc <= word_align(bus.redirect_pc);
        r_discard <= w_outstanding_next;
      end else begin
        if (w_grant) r_pc <= r_pc + XLEN'(4);
        if (bus.imem_rvalid) begin
          if (r_discard != '0) r_discard <= r_discard - CW'(1);
          else                 r_resp_pc <= r_resp_pc + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (bus.redirect),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_empty ? NOP_INST : w_head.inst;
  assign bus.inst_pc    = w_empty ? RESET_PC : w_head.pc;

  a_rvalid_tracked: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rvalid |-> (r_outstanding != '0));

  a_occupancy: assert property (@(posedge clk) disable iff (!reset)
    w_occupancy <= (CW+1)'(DEPTH));

  a_push_room: assert property (@(posedge clk) disable iff (!reset)
    (w_push && w_full) |-> w_pop);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : randomized bench with stream-level reference model     |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_unit;
  import rv32_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t memq[$];

  logic [31:0] exp_pc, exp_issue;
  int   cyc = 0;
  int   gnt_mode, ready_mode, lat_min, lat_max;
  bit   jitter;
  int   n_grant, n_xfer, first_grant_cyc, first_valid_cyc;
  logic prev_hold, prev_redir, prev_grant;
  logic [31:0] prev_pc, prev_inst, prev_grant_addr;
  logic last_req, last_valid, last_rvalid, last_xfer;
  logic [31:0] last_inst_pc, last_grant_addr;
  bit   wrapped;

  // One clock cycle: drive at negedge, observe at negedge+1, commit at posedge.
  task automatic step(input logic redir, input logic [31:0] rpc);
    logic grant, xfer;
    req_t r;
    @(negedge clk);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_gnt    = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
    bus.inst_ready  = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (memq.size() > 0 && memq[0].due <= cyc && (!jitter || $urandom_range(0, 3) != 0)) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(memq[0].addr);
    end
    #1;
    if (prev_redir) check("valid_after_redirect", {31'b0, bus.inst_valid}, 32'd0);
    if (prev_hold) begin
      check("hold_valid", {31'b0, bus.inst_valid}, 32'd1);
      check("hold_pc", bus.inst_pc, prev_pc);
      check("hold_inst", bus.inst, prev_inst);
    end
    if (redir) check("req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
    if (bus.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    xfer = bus.inst_valid & bus.inst_ready;
    if (xfer) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst", bus.inst, mem_word(exp_pc));
      exp_pc += 32'd4;
      n_xfer++;
    end
    grant = bus.imem_req & bus.imem_gnt;
    if (grant) begin
      check("imem_addr", bus.imem_addr, exp_issue);
      if (prev_grant && prev_grant_addr == 32'hFFFF_FFFC) begin
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);
        wrapped = 1'b1;
      end
      r.addr = bus.imem_addr;
      r.due  = cyc + $urandom_range(lat_min, lat_max);
      memq.push_back(r);
      exp_issue += 32'd4;
      n_grant++;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      last_grant_addr = bus.imem_addr;
    end
    if (bus.imem_rvalid) void'(memq.pop_front());
    if (grant) check("outstanding_le_depth", {31'b0, memq.size() <= DEPTH}, 32'd1);
    if (redir) begin
      exp_pc    = rpc & ~32'd3;
      exp_issue = rpc & ~32'd3;
    end
    if (grant) begin
      prev_grant      = 1'b1;
      prev_grant_addr = bus.imem_addr;
    end else if (redir) begin
      prev_grant = 1'b0;
    end
    prev_redir   = redir;
    prev_hold    = bus.inst_valid & ~bus.inst_ready & ~redir;
    prev_pc      = bus.inst_pc;
    prev_inst    = bus.inst;
    last_req     = bus.imem_req;
    last_valid   = bus.inst_valid;
    last_rvalid  = bus.imem_rvalid;
    last_xfer    = xfer;
    last_inst_pc = bus.inst_pc;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    reset           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    #1;
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, NOP_INST);
    check("rst_inst_pc", bus.inst_pc, RST_PC);
    memq.delete();
    exp_pc = RST_PC; exp_issue = RST_PC;
    prev_hold = 1'b0; prev_redir = 1'b0; prev_grant = 1'b0;
    first_grant_cyc = -1; first_valid_cyc = -1;
    n_grant = 0; n_xfer = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("req_after_release", {31'b0, bus.imem_req}, 32'd1);
    check("addr_after_release", bus.imem_addr, RST_PC);
  endtask

  initial begin
    int x0;
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1; jitter = 0; wrapped = 0;

    // Straight-line streaming with single-cycle memory.
    do_reset(2);
    repeat (20) step(1'b0, 32'h0);
    check("first_valid_latency", first_valid_cyc - first_grant_cyc, 32'd2);
    check("stream_progress", {31'b0, n_xfer >= 15}, 32'd1);

    // Decode stalled: issue stops at DEPTH, then drains in order.
    do_reset(2);
    ready_mode = 2;
    repeat (20) step(1'b0, 32'h0);
    check("grants_while_stalled", n_grant, 32'd4);
    check("req_when_full", {31'b0, last_req}, 32'd0);
    check("stalled_inst_pc", last_inst_pc, 32'h0);
    ready_mode = 1;
    n_xfer = 0;
    repeat (12) step(1'b0, 32'h0);
    check("drain_progress", {31'b0, n_xfer >= 6}, 32'd1);

    // Redirect with three requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    repeat (8) step(1'b0, 32'h0);
    check("inflight_before_redirect", memq.size(), 32'd3);
    step(1'b1, 32'h0000_0102);
    step(1'b0, 32'h0);
    check("addr_after_redirect", last_grant_addr, 32'h0000_0100);
    x0 = n_xfer;
    repeat (10) step(1'b0, 32'h0);
    check("post_redirect_delivery", {31'b0, n_xfer > x0}, 32'd1);

    // Redirect coinciding with a response and a decode transfer.
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0200);
    check("coincident_rvalid", {31'b0, last_rvalid}, 32'd1);
    check("coincident_xfer", {31'b0, last_xfer}, 32'd1);
    repeat (8) step(1'b0, 32'h0);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8);
    repeat (8) step(1'b0, 32'h0);
    check("wrap_seen", {31'b0, wrapped}, 32'd1);

    // Randomized traffic with occasional redirects.
    gnt_mode = 2; ready_mode = 0; lat_min = 1; lat_max = 4; jitter = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) step(1'b1, $urandom);
      else                            step(1'b0, 32'h0);
    end

    // Reset while the FIFO holds two entries.
    gnt_mode = 1; ready_mode = 2; lat_min = 1; lat_max = 1; jitter = 0;
    do_reset(2);
    repeat (3) step(1'b0, 32'h0);
    check("prefill_valid", {31'b0, last_valid}, 32'd1);
    do_reset(3);
    ready_mode = 1;
    repeat (10) step(1'b0, 32'h0);
    check("post_reset_delivery", {31'b0, n_xfer > 0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
